// File: rtl/alu_link_master_pkg.sv
// Isa: ALU-level definitions shared by the processor control path and the
// serial ALU link (register width, operation codes, packet layout).
package Isa;

    localparam int REGISTER_SIZE = 8;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } AluOperation;

    // op_code sits in the LSBs, so it is the first field on the wire.
    typedef struct packed {
        logic [REGISTER_SIZE-1:0] op_2;
        logic [REGISTER_SIZE-1:0] op_1;
        AluOperation              op_code;
    } AluPacket;

endpackage

// File: rtl/spi.sv
// Spi: single-bit serial link between the ALU master and the ALU slave.
interface Spi;

    logic nss;
    logic mosi;
    logic miso;

    modport MasterSpi (output nss, output mosi, input miso);
    modport SlaveSpi  (input nss, input mosi, output miso);

endinterface

// File: rtl/alu_link_master.sv
// alu_link_master: serialises {op_2, op_1, op_code} LSB first after a start
// bit, waits for the slave's ready marker, then collects the result LSB first.
module alu_link_master
    import Isa::*;
(
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [$bits(AluOperation)-1:0] i_op_code,
    input  logic [REGISTER_SIZE-1:0]      i_op_1,
    input  logic [REGISTER_SIZE-1:0]      i_op_2,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [REGISTER_SIZE-1:0]      o_result,
    Spi.MasterSpi                         spi
);

    localparam int unsigned N     = $bits(AluPacket);
    localparam int unsigned R     = REGISTER_SIZE;
    localparam int unsigned CNT_W = $clog2((N > R) ? N : R);
    localparam int unsigned TX_IW = $clog2(N);
    localparam int unsigned RX_IW = $clog2(R);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TX,
        S_WAIT,
        S_RX,
        S_DONE
    } link_state_t;

    link_state_t      state;
    link_state_t      next_state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     tx_bits;
    logic [R-1:0]     rx_bits;
    logic [R-1:0]     rx_next;
    logic             nss;
    logic             mosi;
    logic             tx_last;
    logic             rx_last;

    assign tx_last  = (cnt == CNT_W'(N - 1));
    assign rx_last  = (cnt == CNT_W'(R - 1));
    assign spi.nss  = nss;
    assign spi.mosi = mosi;

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and bus/handshake outputs; mosi stays 0 outside START/TX.
    always_comb begin
        next_state = state;
        nss        = 1'b1;
        mosi       = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) next_state = S_START;
            end
            S_START: begin
                nss        = 1'b0;
                mosi       = 1'b1;
                o_busy     = 1'b1;
                next_state = S_TX;
            end
            S_TX: begin
                nss    = 1'b0;
                mosi   = tx_bits[cnt[TX_IW-1:0]];
                o_busy = 1'b1;
                if (tx_last) next_state = S_WAIT;
            end
            S_WAIT: begin
                nss    = 1'b0;
                o_busy = 1'b1;
                if (spi.miso) next_state = S_RX;
            end
            S_RX: begin
                nss    = 1'b0;
                o_busy = 1'b1;
                if (rx_last) next_state = S_DONE;
            end
            S_DONE: begin
                o_done     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Receive word with the current miso bit merged in, so the last bit can
    // reach o_result on the same edge that enters DONE.
    always_comb begin
        rx_next                    = rx_bits;
        rx_next[cnt[RX_IW-1:0]]    = spi.miso;
    end

    // Datapath: bit counter, operand latch, result assembly.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt      <= '0;
            tx_bits  <= '0;
            rx_bits  <= '0;
            o_result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (i_start) tx_bits <= {i_op_2, i_op_1, i_op_code};
                end
                S_TX: begin
                    cnt <= tx_last ? '0 : cnt + 1'b1;
                end
                S_RX: begin
                    rx_bits <= rx_next;
                    if (rx_last) begin
                        cnt      <= '0;
                        o_result <= rx_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_link_master.sv
// tb_alu_link_master: directed tests of the ALU link master against a
// behavioural ALU slave on the same Spi bus.
module tb_alu_link_master;
    import Isa::*;

    localparam int N   = $bits(AluPacket);
    localparam int R   = REGISTER_SIZE;
    localparam int LAT = N + R + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op_code = 2'd0;
    logic [7:0] op_1 = 8'h00;
    logic [7:0] op_2 = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int total = 0;
    int bad   = 0;

    Spi spi_bus ();

    alu_link_master dut (
        .i_clock   (clk),
        .i_reset   (rst_n),
        .i_start   (start),
        .i_op_code (op_code),
        .i_op_1    (op_1),
        .i_op_2    (op_2),
        .o_busy    (busy),
        .o_done    (done),
        .o_result  (result),
        .spi       (spi_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_eval(input logic [N-1:0] p);
        AluPacket pk;
        pk = p;
        case (pk.op_code)
            ALU_ADD: return pk.op_1 + pk.op_2;
            ALU_SUB: return pk.op_1 - pk.op_2;
            ALU_AND: return pk.op_1 & pk.op_2;
            default: return pk.op_1 | pk.op_2;
        endcase
    endfunction

    // Behavioural ALU slave: start bit, N data bits, one compute cycle,
    // ready marker, then R result bits LSB first.
    int           sl_state;
    int           sl_cnt;
    logic [N-1:0] sl_pkt;
    logic [R-1:0] sl_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_state     <= 0;
            sl_cnt       <= 0;
            spi_bus.miso <= 1'b0;
        end else begin
            case (sl_state)
                0: if (!spi_bus.nss && spi_bus.mosi) begin
                    sl_state <= 1;
                    sl_cnt   <= 0;
                end
                1: begin
                    sl_pkt[sl_cnt] <= spi_bus.mosi;
                    sl_cnt         <= sl_cnt + 1;
                    if (sl_cnt == N - 1) sl_state <= 2;
                end
                2: begin
                    sl_res       <= alu_eval(sl_pkt);
                    spi_bus.miso <= 1'b1;
                    sl_state     <= 3;
                end
                3: begin
                    spi_bus.miso <= sl_res[0];
                    sl_cnt       <= 1;
                    sl_state     <= 4;
                end
                default: begin
                    if (sl_cnt == R) begin
                        spi_bus.miso <= 1'b0;
                        sl_state     <= 0;
                    end else begin
                        spi_bus.miso <= sl_res[sl_cnt];
                        sl_cnt       <= sl_cnt + 1;
                    end
                end
            endcase
        end
    end

    // Bus monitor: counts start bits and illegal mosi activity.
    int phase    = 0;
    int starts   = 0;
    int mon_err  = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (spi_bus.nss) begin
            if (spi_bus.mosi !== 1'b0) mon_err++;
            phase = 0;
        end else begin
            if (phase == 0) begin
                if (spi_bus.mosi === 1'b1) starts++;
                else mon_err++;
            end else if (phase > N && spi_bus.mosi !== 1'b0) begin
                mon_err++;
            end
            phase++;
        end
    end

    // Drive a request at a falling edge and return just after the accepting edge.
    task automatic launch(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start   = 1'b1;
        op_code = op;
        op_1    = a;
        op_2    = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count edges after acceptance until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done === 1'b1) return;
        end
        lat = -1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (result !== 8'h00)    begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
        total++; if (spi_bus.nss !== 1'b1)  begin bad++; $display("FAIL reset_nss got=%b exp=1", spi_bus.nss); end
        total++; if (spi_bus.mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", spi_bus.mosi); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ops();
        logic [1:0] ops [4] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR};
        logic [7:0] as  [4] = '{8'h12, 8'h00, 8'hF0, 8'hF0};
        logic [7:0] bs  [4] = '{8'h34, 8'h01, 8'h3C, 8'h3C};
        logic [7:0] exp [4] = '{8'h46, 8'hFF, 8'h30, 8'hFC};
        int lat;
        int s0;
        for (int i = 0; i < 4; i++) begin
            #1 s0 = starts;
            launch(ops[i], as[i], bs[i]);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL op%0d_busy got=%b exp=1", i, busy); end
            start = 1'b0;
            wait_done(lat);
            total++; if (lat !== LAT) begin bad++; $display("FAIL op%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            total++; if (result !== exp[i]) begin bad++; $display("FAIL op%0d_result got=%h exp=%h", i, result, exp[i]); end
            @(negedge clk);
            total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL op%0d_after got=%b%b exp=00", i, done, busy); end
            #1;
            total++; if (starts - s0 !== 1) begin bad++; $display("FAIL op%0d_startbits got=%0d exp=1", i, starts - s0); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int d0;
        launch(ALU_ADD, 8'h05, 8'h03);
        op_code = ALU_SUB;
        op_1    = 8'h10;
        op_2    = 8'h01;
        #1 d0 = done_cnt;
        wait_done(lat);
        total++; if (result !== 8'h08) begin bad++; $display("FAIL b2b_first_result got=%h exp=08", result); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, LAT); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
        #1;
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt - d0); end
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
        start = 1'b0;
        wait_done(lat);
        total++; if (result !== 8'h0F) begin bad++; $display("FAIL b2b_second_result got=%h exp=0F", result); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        int s0;
        #1 s0 = starts;
        launch(ALU_ADD, 8'h77, 8'h11);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)         begin bad++; $display("FAIL midrst_done got=%b exp=0", done); end
        total++; if (result !== 8'h00)      begin bad++; $display("FAIL midrst_result got=%h exp=00", result); end
        total++; if (spi_bus.nss !== 1'b1)  begin bad++; $display("FAIL midrst_nss got=%b exp=1", spi_bus.nss); end
        total++; if (spi_bus.mosi !== 1'b0) begin bad++; $display("FAIL midrst_mosi got=%b exp=0", spi_bus.mosi); end
        @(negedge clk);
        rst_n = 1'b1;
        launch(ALU_ADD, 8'h01, 8'h01);
        start = 1'b0;
        wait_done(lat);
        total++; if (result !== 8'h02) begin bad++; $display("FAIL midrst_result2 got=%h exp=02", result); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT); end
        repeat (2) @(negedge clk);
        #1;
        total++; if (starts - s0 !== 2) begin bad++; $display("FAIL midrst_startbits got=%0d exp=2", starts - s0); end
    endtask

    task automatic test_bus();
        repeat (4) @(negedge clk);
        #1;
        total++; if (mon_err !== 0) begin bad++; $display("FAIL bus_violations got=%0d exp=0", mon_err); end
        total++; if (starts !== 8) begin bad++; $display("FAIL bus_startbits got=%0d exp=8", starts); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_reset_mid();
        test_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
